// File: rtl/game_pkg.sv
// Shared game definitions: phase encoding, row-decode helper and default geometry.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } game_phase_t;

    localparam int ROWS_DEF     = 8;
    localparam int SCAN_DIV_DEF = 25000;
    localparam int HOLD_CYC_DEF = 1000;

    // Widest row count the decode helper supports; callers slice the low ROWS bits.
    localparam int MAX_ROWS = 32;

    // Active-low one-cold decode: row 0 drives the MSB of a rows-wide field low.
    function automatic logic [MAX_ROWS-1:0] onehot_low(input int idx, input int rows);
        onehot_low = ~(MAX_ROWS'(1) << (rows - 1 - idx));
    endfunction

endpackage

// File: rtl/row_scanner.sv
// Dot-matrix row scanner: clock divider, row index and registered one-cold row select.
module row_scanner
    import game_pkg::*;
#(
    parameter int ROWS     = ROWS_DEF,
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    output logic [ROWS-1:0]          dot_row,
    output logic [$clog2(ROWS)-1:0]  row_idx
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [MAX_ROWS-1:0] row_dec;

    assign tick = (div_cnt == LAST_DIV);

    // Decode the row currently held in row_idx; registered below so dot_row trails by one cycle.
    always_comb begin
        row_dec = onehot_low(int'(row_idx), ROWS);
    end

    // Divider and row stepping run only while enabled; otherwise park at row 0 with all rows off.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div_cnt <= '0;
            row_idx <= '0;
            dot_row <= '1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                row_idx <= (row_idx == LAST_ROW) ? '0 : row_idx + ROW_W'(1);
            end
            dot_row <= row_dec[ROWS-1:0];
        end
    end

endmodule

// File: rtl/match_scan_engine.sv
// Game-phase FSM, row scan and boss/player hold-to-score matcher with combo tracking.
module match_scan_engine
    import game_pkg::*;
#(
    parameter int ROWS     = ROWS_DEF,
    parameter int SCAN_DIV = SCAN_DIV_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int STATE_W  = 2,
    parameter int COMBO_W  = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     finish,
    input  logic [STATE_W-1:0]       boss_state,
    input  logic [STATE_W-1:0]       player_state,
    output logic [ROWS-1:0]          dot_row,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     active,
    output logic                     add_pulse,
    output logic                     miss_pulse,
    output logic [COMBO_W-1:0]       combo
);

    localparam int HOLD_W = $clog2(HOLD_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    game_phase_t        state, next_state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               scored;
    logic [STATE_W-1:0] prev_boss;
    logic               entering;
    logic               correct;
    logic               change;
    logic               hold_done;

    // Combo count sticks at its maximum instead of wrapping.
    function automatic logic [COMBO_W-1:0] sat_inc(input logic [COMBO_W-1:0] v);
        sat_inc = (&v) ? v : v + COMBO_W'(1);
    endfunction

    // Phase register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next phase; finish takes priority over start whenever both are seen.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (finish) next_state = DONE;
                     else if (start) next_state = PLAY;
            PLAY:    if (finish) next_state = DONE;
            DONE:    if (!finish && start) next_state = PLAY;
            default: next_state = IDLE;
        endcase
    end

    assign active    = (state == PLAY);
    assign entering  = (state != PLAY) && (next_state == PLAY);
    assign correct   = active && (boss_state == player_state);
    assign change    = active && (boss_state != prev_boss);
    assign hold_done = (hold_cnt == HOLD_LAST);

    // Hold-to-score, target-change and combo bookkeeping; a target change overrides a pending add.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt   <= '0;
            scored     <= 1'b0;
            prev_boss  <= '0;
            add_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            combo      <= '0;
        end else begin
            prev_boss  <= boss_state;
            add_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            if (entering) begin
                combo    <= '0;
                hold_cnt <= '0;
                scored   <= 1'b0;
            end else if (!active) begin
                hold_cnt <= '0;
            end else if (change) begin
                if (!scored) begin
                    miss_pulse <= 1'b1;
                    combo      <= '0;
                end
                scored   <= 1'b0;
                hold_cnt <= '0;
            end else if (correct) begin
                if (hold_done) begin
                    add_pulse <= 1'b1;
                    hold_cnt  <= '0;
                    scored    <= 1'b1;
                    // Only the first score on a target extends the combo.
                    if (!scored) begin
                        combo <= sat_inc(combo);
                    end
                end else begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    row_scanner #(
        .ROWS     (ROWS),
        .SCAN_DIV (SCAN_DIV)
    ) u_row_scanner (
        .clk     (clk),
        .reset   (reset),
        .en      (active),
        .dot_row (dot_row),
        .row_idx (row_idx)
    );

endmodule

// File: tb/tb_match_scan_engine.sv
// Directed bench for match_scan_engine with small scan/hold/combo geometry.
module tb_match_scan_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       finish = 1'b0;
    logic [1:0] boss_state = 2'd0;
    logic [1:0] player_state = 2'd0;
    logic [7:0] dot_row;
    logic [2:0] row_idx;
    logic       active;
    logic       add_pulse;
    logic       miss_pulse;
    logic [1:0] combo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       s;
        logic       f;
        logic [1:0] b;
        logic [1:0] p;
        logic       act;
        logic       add;
        logic       miss;
        logic [1:0] combo;
    } vec_t;

    vec_t vecs[$];

    match_scan_engine #(
        .ROWS     (8),
        .SCAN_DIV (4),
        .HOLD_CYC (5),
        .STATE_W  (2),
        .COMBO_W  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .finish       (finish),
        .boss_state   (boss_state),
        .player_state (player_state),
        .dot_row      (dot_row),
        .row_idx      (row_idx),
        .active       (active),
        .add_pulse    (add_pulse),
        .miss_pulse   (miss_pulse),
        .combo        (combo)
    );

    always #5 clk = ~clk;

    // Drive inputs, take one clock edge, then settle before sampling.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic [1:0] b, input logic [1:0] p);
        reset        = r;
        start        = s;
        finish       = f;
        boss_state   = b;
        player_state = p;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " dot_row"}, dot_row, 8'hFF);
        check({tag, " row_idx"}, 8'(row_idx), 8'd0);
        check({tag, " active"}, 8'(active), 8'd0);
        check({tag, " add"}, 8'(add_pulse), 8'd0);
        check({tag, " miss"}, 8'(miss_pulse), 8'd0);
        check({tag, " combo"}, 8'(combo), 8'd0);
    endtask

    function automatic void push(input logic s, input logic f, input logic [1:0] b,
                                 input logic [1:0] p, input logic act, input logic add,
                                 input logic miss, input logic [1:0] c);
        vec_t v;
        v.s = s; v.f = f; v.b = b; v.p = p;
        v.act = act; v.add = add; v.miss = miss; v.combo = c;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0] exp_dot;
        logic [1:0] exp_c[5];
        logic [1:0] tgt;
        logic [1:0] prev_c;

        // Match/score table, starting from DONE with combo 0 and prev boss 0.
        push(1, 0, 2'd2, 2'd0, 1, 0, 0, 2'd0);            // enter PLAY
        for (int i = 1; i <= 12; i++) begin                // hold match 12 cycles
            push(0, 0, 2'd2, 2'd2, 1, (i == 5 || i == 10), 0, (i >= 5) ? 2'd1 : 2'd0);
        end
        push(0, 0, 2'd3, 2'd0, 1, 0, 0, 2'd1);            // change after scored: no miss
        for (int i = 0; i < 4; i++) push(0, 0, 2'd3, 2'd3, 1, 0, 0, 2'd1);
        push(0, 0, 2'd3, 2'd0, 1, 0, 0, 2'd1);            // mismatch breaks hold
        for (int i = 0; i < 4; i++) push(0, 0, 2'd3, 2'd3, 1, 0, 0, 2'd1);
        push(0, 0, 2'd3, 2'd3, 1, 1, 0, 2'd2);            // fifth fresh match scores
        push(0, 0, 2'd1, 2'd0, 1, 0, 0, 2'd2);            // leave scored target 3
        push(0, 0, 2'd3, 2'd0, 1, 0, 1, 2'd0);            // 1->3 unscored: miss, combo 2->0
        // Five scored targets; first change leaves unscored target 3 behind.
        exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd3; exp_c[4] = 2'd3;
        for (int t = 0; t < 5; t++) begin
            tgt    = (t % 2 == 0) ? 2'd1 : 2'd2;
            prev_c = (t == 0) ? 2'd0 : exp_c[t-1];
            push(0, 0, tgt, tgt, 1, 0, (t == 0), prev_c);
            for (int i = 0; i < 4; i++) push(0, 0, tgt, tgt, 1, 0, 0, prev_c);
            push(0, 0, tgt, tgt, 1, 1, 0, exp_c[t]);
        end
        push(0, 1, 2'd1, 2'd1, 0, 0, 0, 2'd3);            // finish mid-hold: no add

        // Reset state.
        step(1, 0, 0, 2'd0, 2'd1);
        step(1, 0, 0, 2'd0, 2'd1);
        check_reset_state("reset");

        // Row scan: 4 cycles per row, MSB-first one-cold.
        step(0, 1, 0, 2'd0, 2'd1);
        check("scan start active", 8'(active), 8'd1);
        check("scan start dot", dot_row, 8'hFF);
        for (int k = 1; k <= 36; k++) begin
            step(0, 0, 0, 2'd0, 2'd1);
            exp_dot = ~(8'h80 >> (((k - 1) / 4) % 8));
            check($sformatf("scan k%0d dot", k), dot_row, exp_dot);
            check($sformatf("scan k%0d row", k), 8'(row_idx), 8'((k / 4) % 8));
            check($sformatf("scan k%0d add", k), 8'(add_pulse), 8'd0);
        end
        step(0, 0, 1, 2'd0, 2'd1);
        check("finish active", 8'(active), 8'd0);
        step(0, 0, 0, 2'd0, 2'd1);
        check("finish dot", dot_row, 8'hFF);
        check("finish row", 8'(row_idx), 8'd0);

        // Table-driven match/miss/combo sequence.
        for (int i = 0; i < vecs.size(); i++) begin
            step(0, vecs[i].s, vecs[i].f, vecs[i].b, vecs[i].p);
            check($sformatf("v%0d active", i), 8'(active), 8'(vecs[i].act));
            check($sformatf("v%0d add", i), 8'(add_pulse), 8'(vecs[i].add));
            check($sformatf("v%0d miss", i), 8'(miss_pulse), 8'(vecs[i].miss));
            check($sformatf("v%0d combo", i), 8'(combo), 8'(vecs[i].combo));
        end

        // start and finish together from IDLE land in DONE.
        step(1, 0, 0, 2'd0, 2'd0);
        step(0, 1, 1, 2'd0, 2'd0);
        check("idle s+f active", 8'(active), 8'd0);
        step(0, 1, 0, 2'd0, 2'd0);
        check("done restart active", 8'(active), 8'd1);

        // Reset in the middle of a hold.
        step(0, 0, 1, 2'd1, 2'd1);
        step(0, 1, 0, 2'd1, 2'd1);
        check("hold play active", 8'(active), 8'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'd1, 2'd1);
        check("hold pre-reset add", 8'(add_pulse), 8'd0);
        check("hold pre-reset dot", dot_row, 8'h7F);
        step(1, 0, 0, 2'd1, 2'd1);
        check_reset_state("midhold");
        step(0, 0, 0, 2'd1, 2'd1);
        check("post-reset add", 8'(add_pulse), 8'd0);
        check("post-reset active", 8'(active), 8'd0);
        step(0, 0, 0, 2'd1, 2'd1);
        check("post-reset add2", 8'(add_pulse), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_scan_engine.md
Name: match_scan_engine

Overview:
- Parametrised successor to the game top's hard-wired row scan and hold-to-score logic: one block owns the game-phase FSM, the dot-matrix row scanner and the boss/player match scorer.
- Sits between the boss/player pattern generators (consume row_idx, drive boss_state/player_state) and score_and_time (consumes add_pulse).
- Adds what the fixed version lacks: configurable rows, divider, hold time and state width; a single-cycle score pulse; a miss pulse; a saturating combo count.

Parameters:
- ROWS, 8: matrix rows scanned; >=2.
- SCAN_DIV, 25000: clk cycles per row step; >=2.
- HOLD_CYC, 1000: consecutive matched cycles per score pulse; >=2.
- STATE_W, 2: width of boss/player action codes.
- COMBO_W, 7: combo counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level/pulse; begin or restart play.
- finish  in  1  level/pulse; end play.
- boss_state  in  STATE_W  current target action.
- player_state  in  STATE_W  current player action.
- dot_row  out  ROWS  active-low one-cold row select.
- row_idx  out  $clog2(ROWS)  index of driven row.
- active  out  1  high in PLAY.
- add_pulse  out  1  one-cycle score strobe.
- miss_pulse  out  1  one-cycle miss strobe.
- combo  out  COMBO_W  consecutive scored targets.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on posedge clk.
- Reset values: FSM=IDLE, dot_row=all ones, row_idx=0, active=0, add_pulse=0, miss_pulse=0, combo=0, all internal counters 0, scored flag 0.
- FSM: IDLE, PLAY, DONE.
  - IDLE->PLAY on start.
  - PLAY->DONE on finish.
  - DONE->PLAY on start.
  - finish dominates start in the same cycle: IDLE+finish -> DONE.
  - Entering PLAY clears combo, scan state, hold counter and scored flag.
- Scan: divider counts 0..SCAN_DIV-1 only in PLAY; tick when count==SCAN_DIV-1, then the count wraps to 0.
  - On tick, row_idx <= (row_idx==ROWS-1) ? 0 : row_idx+1.
  - dot_row is registered: bit (ROWS-1-row_idx) low, all others high, updated the cycle after row_idx changes.
  - Row 0 -> MSB low.
  - Outside PLAY: dot_row all ones, row_idx=0, divider=0.
- Match: correct = active && (boss_state==player_state).
  - Hold counter increments while correct.
  - When correct and count==HOLD_CYC-1: add_pulse=1 for exactly one cycle, count <= 0, scored flag <= 1.
  - Continuous matching re-scores every HOLD_CYC cycles.
  - !correct clears the hold counter the same cycle; no partial credit.
- Target change: prev_boss register, updated every cycle in PLAY.
  - On boss_state != prev_boss in PLAY:
    - If scored==0, miss_pulse=1 for one cycle and combo <= 0.
    - Otherwise no miss.
    - Either way scored <= 0 and hold counter <= 0.
  - If an add would fire in the same cycle as a target change, the change wins: no add, and no miss on the old target unless it was unscored.
- Combo: +1 on each add_pulse (first add per target only; repeat adds on the same target do not increment), saturates at 2^COMBO_W-1, cleared on miss or PLAY entry.
- Registered outputs: add_pulse/miss_pulse latency is 1 cycle after the qualifying clk edge.
- Leaving PLAY mid-hold: counter cleared, no add, no miss.
- Reset mid-operation: immediate return to reset values on the next edge.

Decomposition:
- Shared package game_pkg holds:
  - enum game_phase_t {IDLE, PLAY, DONE};
  - function onehot_low(idx) for row decode;
  - defaults ROWS_DEF=8, SCAN_DIV_DEF=25000, HOLD_CYC_DEF=1000.
- One natural sub-module, row_scanner (divider + row_idx + dot_row, enabled by active), reusable by the menu screen.
- The FSM and match/combo logic stay in the top.

Test Plan:
- ROWS=8, SCAN_DIV=4, start pulse -> dot_row sequence 7F,BF,DF,EF,F7,FB,FD,FE,7F, each held 4 cycles; finish -> FF next cycle, row_idx=0.
- HOLD_CYC=5, boss=player=2 held 12 cycles in PLAY -> add_pulse at cycles 5 and 10 only, each 1 cycle wide; combo=1.
- Match for 4 cycles, mismatch 1 cycle, match 4 cycles -> no add_pulse, hold counter restarts.
- Boss changes 1->3 with no prior add -> miss_pulse one cycle, combo 2->0; change after a scored target -> no miss, combo unchanged.
- COMBO_W=2, score 5 consecutive targets -> combo 1,2,3,3,3.
- start and finish asserted together in IDLE -> DONE, active=0; reset asserted mid-hold at count 3 -> next cycle all outputs at reset values, no add.
